// File: rtl/remote_cmd_arb_if.sv
// remote_cmd_arb_if: signal bundle for remote_cmd_arb.
//
// Groups the requester, transmitter and receiver handshakes of the arbiter.
//   slave  modport : the arbiter side (remote_cmd_arb).
//   master modport : the environment side (requesters, transmitter, receiver).
//
// Signals
//   req0/req1       level request per requester, held until its done pulse
//   cmd0/cmd1       command byte per requester
//   data0/data1     data word per requester
//   done0/done1     one-cycle completion pulse per requester
//   rsp             response byte, held until the next completion
//   err             response timed out (only with RESP_TIMEOUT_EN)
//   busy            arbiter is not idle
//   send_cmd        one-cycle launch pulse to the serial transmitter
//   cmd/data        registered command byte / data word to the transmitter
//   cmd_sent        transmitter pulse: all three bytes shifted out
//   resp_rdy        receiver level: response byte available
//   resp            response byte from the receiver
//   clr_resp_rdy    one-cycle pulse that knocks down resp_rdy
interface remote_cmd_arb_if;
    logic        req0;
    logic        req1;
    logic [7:0]  cmd0;
    logic [7:0]  cmd1;
    logic [15:0] data0;
    logic [15:0] data1;
    logic        done0;
    logic        done1;
    logic [7:0]  rsp;
    logic        err;
    logic        busy;
    logic        send_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy;

    modport slave (
        input  req0, req1, cmd0, cmd1, data0, data1, cmd_sent, resp_rdy, resp,
        output done0, done1, rsp, err, busy, send_cmd, cmd, data, clr_resp_rdy
    );

    modport master (
        output req0, req1, cmd0, cmd1, data0, data1, cmd_sent, resp_rdy, resp,
        input  done0, done1, rsp, err, busy, send_cmd, cmd, data, clr_resp_rdy
    );
endinterface

// File: rtl/remote_cmd_arb.sv
// remote_cmd_arb: round-robin arbiter between two requesters sharing one
// remote serial command link.
//
// A granted requester's command byte and data word are latched and handed to
// the transmitter with a one-cycle send_cmd pulse. After the transmitter
// reports cmd_sent, the arbiter waits for the receiver's response, clears the
// receiver's ready flag, and returns the response to the requester with a
// one-cycle done pulse.
//
// Optional feature macro: RESP_TIMEOUT_EN
//   When defined, a response that does not arrive within TMO_CYCLES cycles of
//   entering WAIT_RESP completes the transaction with rsp=8'h00 and err=1.
//   When undefined, err is tied low and WAIT_RESP waits indefinitely.
//
// Parameters
//   TMO_CYCLES  response timeout in clk cycles, 2..65535
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    remote_cmd_arb_if.slave (requester, transmitter, receiver signals)
module remote_cmd_arb #(
    parameter int unsigned TMO_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    remote_cmd_arb_if.slave bus
);

    if (TMO_CYCLES < 2 || TMO_CYCLES > 65535) begin : g_tmo_range
        $error("remote_cmd_arb: TMO_CYCLES must be in 2..65535");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitSent,
        StWaitResp,
        StComplete
    } state_e;

    state_e      state_q, state_d;
    logic        gnt_id_q, gnt_id_d;
    logic        last_gnt_q, last_gnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  rsp_q, rsp_d;
    logic        send_cmd_q, send_cmd_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        clr_resp_rdy;
    logic        pick1;

`ifdef RESP_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TMO_CYCLES - 1);

    logic        err_q, err_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Requester 1 wins when it is alone, or on a tie when 0 was served last.
    assign pick1 = bus.req1 && (!bus.req0 || !last_gnt_q);

    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        last_gnt_d   = last_gnt_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        rsp_d        = rsp_q;
        send_cmd_d   = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        clr_resp_rdy = 1'b0;
`ifdef RESP_TIMEOUT_EN
        err_d        = err_q;
        tmo_cnt_d    = tmo_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                // A response showing up with no transaction open is stale:
                // knock it down and drop it without touching rsp.
                if (bus.resp_rdy) begin
                    clr_resp_rdy = 1'b1;
                end
                if (bus.req0 || bus.req1) begin
                    gnt_id_d = pick1;
                    cmd_d    = pick1 ? bus.cmd1 : bus.cmd0;
                    data_d   = pick1 ? bus.data1 : bus.data0;
                    state_d  = StLaunch;
                end
            end

            StLaunch: begin
                // send_cmd is registered out of LAUNCH, so the transmitter
                // sees it two edges after the request is sampled.
                send_cmd_d = 1'b1;
                state_d    = StWaitSent;
            end

            StWaitSent: begin
                if (bus.cmd_sent) begin
                    state_d = StWaitResp;
`ifdef RESP_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            StWaitResp: begin
                // done is set on the edge into COMPLETE so it lands exactly
                // one cycle after resp_rdy.
                if (bus.resp_rdy) begin
                    clr_resp_rdy = 1'b1;
                    rsp_d        = bus.resp;
                    done0_d      = !gnt_id_q;
                    done1_d      = gnt_id_q;
                    state_d      = StComplete;
`ifdef RESP_TIMEOUT_EN
                    err_d        = 1'b0;
                end else if (tmo_cnt_q == TmoLast) begin
                    rsp_d   = 8'h00;
                    err_d   = 1'b1;
                    done0_d = !gnt_id_q;
                    done1_d = gnt_id_q;
                    state_d = StComplete;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                end
            end

            StComplete: begin
                last_gnt_d = gnt_id_q;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_id_q   <= 1'b0;
            last_gnt_q <= 1'b1;  // requester 0 wins the first tie
            cmd_q      <= 8'h00;
            data_q     <= 16'h0000;
            rsp_q      <= 8'h00;
            send_cmd_q <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= last_gnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            rsp_q      <= rsp_d;
            send_cmd_q <= send_cmd_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
        end
    end

`ifdef RESP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            tmo_cnt_q <= 16'h0000;
        end else begin
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.done0        = done0_q;
    assign bus.done1        = done1_q;
    assign bus.rsp          = rsp_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.send_cmd     = send_cmd_q;
    assign bus.cmd          = cmd_q;
    assign bus.data         = data_q;
    // Gated so the receiver never sees a clear while reset is held.
    assign bus.clr_resp_rdy = clr_resp_rdy & rst_n;

endmodule

// File: tb/tb_remote_cmd_arb.sv
module tb_remote_cmd_arb;

    localparam int TmoCycles = 8;

    logic clk;
    logic rst_n;

    remote_cmd_arb_if bus ();

    remote_cmd_arb #(
        .TMO_CYCLES(TmoCycles)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [7:0]  rsp;
        logic        err;
    } exp_t;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [7:0]  c0;
        logic [15:0] d0;
        logic [7:0]  c1;
        logic [15:0] d1;
        int          dly;
        logic [7:0]  rv;
        logic        eg;
        logic [7:0]  ec;
        logic [15:0] ed;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare launches against the head entry, pop on done.
    always @(negedge clk) begin
        if (rst_n && bus.send_cmd) begin
            if (exp_q.size() == 0) begin
                check("send_cmd_unexpected", 32'd1, 32'd0);
            end else begin
                check("launch_cmd", bus.cmd, exp_q[0].cmd);
                check("launch_data", bus.data, exp_q[0].data);
            end
        end
        if (rst_n && (bus.done0 || bus.done1)) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", {bus.done1, bus.done0}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_id", {bus.done1, bus.done0}, e.gnt ? 2'b10 : 2'b01);
                check("done_rsp", bus.rsp, e.rsp);
                check("done_err", bus.err, e.err);
            end
        end
    end

    task automatic push_exp(input logic eg, input logic [7:0] ec, input logic [15:0] ed,
                            input logic [7:0] rv, input logic er);
        exp_t e;
        e.gnt  = eg;
        e.cmd  = ec;
        e.data = ed;
        e.rsp  = rv;
        e.err  = er;
        exp_q.push_back(e);
    endtask

    // Starts in the cycle the request is first visible to an idle arbiter.
    task automatic wait_launch();
        int n = 0;
        while (!bus.send_cmd && n < 60) begin
            tick();
            n++;
        end
        check("send_cmd_seen", bus.send_cmd, 1'b1);
        check("req_to_send_latency", n, 2);
    endtask

    // Ends in the first WAIT_RESP cycle.
    task automatic launch_done(input int dly);
        for (int i = 0; i < dly; i++) tick();
        bus.cmd_sent = 1'b1;
        tick();
        bus.cmd_sent = 1'b0;
        check("send_cmd_single", bus.send_cmd, 1'b0);
        check("busy_wait_resp", bus.busy, 1'b1);
    endtask

    // Called in the COMPLETE cycle.
    task automatic tail(input logic eg, input logic [7:0] ec, input logic [15:0] ed,
                        input logic drop);
        check("done_pulse", {bus.done1, bus.done0}, eg ? 2'b10 : 2'b01);
        check("cmd_stable", bus.cmd, ec);
        check("data_stable", bus.data, ed);
        if (drop) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        tick();
        check("done_cleared", {bus.done1, bus.done0}, 2'b00);
    endtask

    task automatic serve(input logic eg, input logic [7:0] ec, input logic [15:0] ed,
                         input logic [7:0] rv, input int dly, input int rwait, input logic drop);
        push_exp(eg, ec, ed, rv, 1'b0);
        wait_launch();
        launch_done(dly);
        for (int i = 0; i < rwait; i++) tick();
        check("no_early_done", {bus.done1, bus.done0}, 2'b00);
        bus.resp_rdy = 1'b1;
        bus.resp     = rv;
        #1;
        check("clr_same_cycle", bus.clr_resp_rdy, 1'b1);
        tick();
        bus.resp_rdy = 1'b0;
        tail(eg, ec, ed, drop);
    endtask

`ifdef RESP_TIMEOUT_EN
    task automatic serve_tmo(input logic eg, input logic [7:0] ec, input logic [15:0] ed,
                             input int dly);
        int n = 0;
        push_exp(eg, ec, ed, 8'h00, 1'b1);
        wait_launch();
        launch_done(dly);
        while (!(bus.done0 || bus.done1) && n < 40) begin
            tick();
            n++;
        end
        // n counts edges after the first WAIT_RESP cycle; +1 counts from the entry edge.
        check("tmo_latency", n + 1, TmoCycles + 1);
        tail(eg, ec, ed, 1'b1);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            r0    r1    c0     d0        c1     d1        dly rv     eg    ec     ed
        vecs[0] = '{1'b1, 1'b0, 8'h05, 16'h1234, 8'hEE, 16'hEEEE, 28, 8'hA5, 1'b0, 8'h05, 16'h1234};
        vecs[1] = '{1'b0, 1'b1, 8'h11, 16'h1111, 8'h3C, 16'hBEEF, 3,  8'h5A, 1'b1, 8'h3C, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 8'h21, 16'h2121, 8'h31, 16'h3131, 0,  8'h77, 1'b0, 8'h21, 16'h2121};
        vecs[3] = '{1'b1, 1'b1, 8'h42, 16'h4242, 8'h52, 16'h5252, 1,  8'h88, 1'b1, 8'h52, 16'h5252};
        vecs[4] = '{1'b0, 1'b1, 8'h63, 16'h6363, 8'h73, 16'h7373, 2,  8'h99, 1'b1, 8'h73, 16'h7373};
        vecs[5] = '{1'b1, 1'b1, 8'h84, 16'h8484, 8'h94, 16'h9494, 4,  8'hC3, 1'b0, 8'h84, 16'h8484};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 16'hFFFF, 8'h00, 16'h0000, 0,  8'h3E, 1'b0, 8'hFF, 16'hFFFF};

        rst_n        = 1'b0;
        bus.req0     = 1'b0;
        bus.req1     = 1'b0;
        bus.cmd0     = 8'h00;
        bus.cmd1     = 8'h00;
        bus.data0    = 16'h0000;
        bus.data1    = 16'h0000;
        bus.cmd_sent = 1'b0;
        bus.resp_rdy = 1'b0;
        bus.resp     = 8'h00;
        repeat (2) tick();

        check("rst_send_cmd", bus.send_cmd, 1'b0);
        check("rst_clr", bus.clr_resp_rdy, 1'b0);
        check("rst_done", {bus.done1, bus.done0}, 2'b00);
        check("rst_err", bus.err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rsp", bus.rsp, 8'h00);
        check("rst_cmd", bus.cmd, 8'h00);
        check("rst_data", bus.data, 16'h0000);

        rst_n = 1'b1;
        tick();

        // Both requesters raised together and held: 0 wins the first tie, then alternate.
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.cmd0  = 8'hA0;
        bus.data0 = 16'h0A0A;
        bus.cmd1  = 8'hB1;
        bus.data1 = 16'h1B1B;
        serve(1'b0, 8'hA0, 16'h0A0A, 8'h10, 2, 2, 1'b0);
        serve(1'b1, 8'hB1, 16'h1B1B, 8'h20, 1, 2, 1'b0);
        serve(1'b0, 8'hA0, 16'h0A0A, 8'h30, 0, 2, 1'b1);

        for (int i = 0; i < 7; i++) begin
            bus.req0  = vecs[i].r0;
            bus.req1  = vecs[i].r1;
            bus.cmd0  = vecs[i].c0;
            bus.data0 = vecs[i].d0;
            bus.cmd1  = vecs[i].c1;
            bus.data1 = vecs[i].d1;
            serve(vecs[i].eg, vecs[i].ec, vecs[i].ed, vecs[i].rv, vecs[i].dly, 2, 1'b1);
        end

        // Stale response while idle: cleared, dropped, rsp untouched.
        bus.resp_rdy = 1'b1;
        bus.resp     = 8'h5C;
        #1;
        check("stale_clr", bus.clr_resp_rdy, 1'b1);
        tick();
        bus.resp_rdy = 1'b0;
        #1;
        check("stale_clr_single", bus.clr_resp_rdy, 1'b0);
        check("stale_rsp_kept", bus.rsp, 8'h3E);
        tick();
        check("stale_not_busy", bus.busy, 1'b0);
        check("stale_no_done", {bus.done1, bus.done0}, 2'b00);

`ifdef RESP_TIMEOUT_EN
        bus.req1  = 1'b1;
        bus.cmd1  = 8'h9A;
        bus.data1 = 16'h9A9A;
        serve_tmo(1'b1, 8'h9A, 16'h9A9A, 1);
        bus.req0  = 1'b1;
        bus.cmd0  = 8'h4D;
        bus.data0 = 16'h4D4D;
        serve(1'b0, 8'h4D, 16'h4D4D, 8'h4D, 1, 2, 1'b1);
        // Response arrives in the same cycle the timeout would fire.
        bus.req1  = 1'b1;
        bus.cmd1  = 8'hD2;
        bus.data1 = 16'hD2D2;
        serve(1'b1, 8'hD2, 16'hD2D2, 8'hD2, 1, TmoCycles - 1, 1'b1);
`else
        bus.req1  = 1'b1;
        bus.cmd1  = 8'h9A;
        bus.data1 = 16'h9A9A;
        serve(1'b1, 8'h9A, 16'h9A9A, 8'h9A, 1, 40, 1'b1);
        check("err_tied_low", bus.err, 1'b0);
`endif

        // Reset in WAIT_SENT aborts the transaction outright.
        bus.req0  = 1'b1;
        bus.cmd0  = 8'h66;
        bus.data0 = 16'h6666;
        push_exp(1'b0, 8'h66, 16'h6666, 8'h00, 1'b0);
        wait_launch();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_send_cmd", bus.send_cmd, 1'b0);
        check("arst_done", {bus.done1, bus.done0}, 2'b00);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_err", bus.err, 1'b0);
        check("arst_rsp", bus.rsp, 8'h00);
        check("arst_cmd", bus.cmd, 8'h00);
        check("arst_data", bus.data, 16'h0000);
        exp_q.delete();
        bus.req0 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("arst_idle_after", bus.busy, 1'b0);
        bus.req1  = 1'b1;
        bus.cmd1  = 8'h77;
        bus.data1 = 16'h7777;
        serve(1'b1, 8'h77, 16'h7777, 8'hE7, 1, 2, 1'b1);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/remote_cmd_arb.md
REMOTE_CMD_ARB -- requirements
Module: remote_cmd_arb

Interface
REQ-001 Parameter TMO_CYCLES, default 1024: response timeout in clk cycles; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  level request from requester 0 and requester 1; held until that requester's done pulse.
REQ-005 cmd0, cmd1  input  8 each  command byte of requester 0 and requester 1.
REQ-006 data0, data1  input  16 each  data word of requester 0 and requester 1.
REQ-007 done0, done1  output  1 each  one-cycle completion pulse to requester 0 and requester 1.
REQ-008 rsp  output  8  response byte, valid in the done-pulse cycle and held until the next transaction completes.
REQ-009 err  output  1  set with done when the transaction timed out; otherwise 0.
REQ-010 busy  output  1  high whenever the block is not in IDLE.
REQ-011 send_cmd  output  1  one-cycle launch pulse to the serial command transmitter.
REQ-012 cmd  output  8  registered command byte to the transmitter.
REQ-013 data  output  16  registered data word to the transmitter.
REQ-014 cmd_sent  input  1  pulse from the transmitter: all 3 bytes shifted out.
REQ-015 resp_rdy  input  1  level from the receiver: response byte available.
REQ-016 resp  input  8  response byte from the receiver.
REQ-017 clr_resp_rdy  output  1  one-cycle pulse that knocks down resp_rdy.

Function
REQ-018 The FSM shall have the states IDLE, LAUNCH, WAIT_SENT, WAIT_RESP and COMPLETE.
REQ-019 In IDLE with a request pending: grant 0 if only req0 is high; grant 1 if only req1 is high; if both are high, grant the requester not granted last (round-robin).
REQ-020 On grant: latch the granted requester's cmd/data into cmd/data and record gnt_id; next state LAUNCH.
REQ-021 In LAUNCH: send_cmd=1 for exactly that cycle; next state WAIT_SENT.
REQ-022 In WAIT_SENT: stay until cmd_sent=1, then go to WAIT_RESP; resp_rdy is ignored in this state.
REQ-023 In WAIT_RESP with resp_rdy=1: clr_resp_rdy=1 in the same cycle; latch resp into rsp; err<=0; next state COMPLETE.
REQ-024 In COMPLETE: pulse done[gnt_id] for one cycle; update last-grant to gnt_id; next state IDLE.
REQ-025 Request-to-send_cmd latency shall be exactly 2 cycles; resp_rdy-to-done latency shall be exactly 1 cycle.
REQ-026 A stale resp_rdy=1 observed in IDLE shall produce a clr_resp_rdy pulse and be discarded, with no done and no change to rsp.
REQ-027 Requests arriving while busy=1 shall be held off until the block returns to IDLE; if req stays high after done, it counts as a new request.
REQ-028 cmd/data outputs shall stay stable from LAUNCH until the next grant.

Reset
REQ-029 While rst_n=0: state=IDLE; send_cmd, clr_resp_rdy, done0, done1, err and busy=0; rsp, cmd and data=0; last-grant=1 (so req0 wins the first tie); timeout counter=0.
REQ-030 Reset asserted mid-transaction shall abort it immediately, with no done pulse after release.

Configuration
REQ-031 With RESP_TIMEOUT_EN defined: a 16-bit counter clears on entry to WAIT_RESP and increments each cycle there; when it reaches TMO_CYCLES-1 without resp_rdy, next state COMPLETE with rsp<=8'h00 and err<=1.
REQ-032 If resp_rdy and the timeout occur in the same cycle, the response shall win (err=0).
REQ-033 Without RESP_TIMEOUT_EN: no counter; err is tied to 0; WAIT_RESP waits indefinitely.

Verification
REQ-034 req0=1, cmd0=8'h05, data0=16'h1234; cmd_sent 30 cycles later; resp_rdy with resp=8'hA5 -> send_cmd 2 cycles after req0; cmd=05, data=1234; clr_resp_rdy with resp_rdy; done0 next cycle with rsp=A5, err=0.
REQ-035 req0 and req1 raised in the same cycle, both held across 3 transactions -> grants in order 0, 1, 0; done0/done1 alternate.
REQ-036 resp_rdy=1 while IDLE -> one clr_resp_rdy pulse; no done; rsp unchanged.
REQ-037 RESP_TIMEOUT_EN, TMO_CYCLES=8, no resp_rdy -> done asserted 9 cycles after entering WAIT_RESP with err=1, rsp=00; next request proceeds normally.
REQ-038 rst_n dropped in WAIT_SENT -> all outputs 0 asynchronously; no done after release; req1 then granted as a fresh request.
